// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divider
// calculation used by both the receive and transmit baud generators.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_e;

   // Clock cycles per oversample tick, truncated toward zero.
   function automatic int unsigned uart_div(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned oversample);
      return clk_hz / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, with a
// restart input that realigns the tick phase to the start-bit edge.
module uart_rx_tick #(
   parameter int unsigned DIV = 54
) (
   input  logic clk100M,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // Free-running divider, cleared on restart or on wrap.
   always_ff @(posedge clk100M or negedge rst_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!rst_n)
         cnt <= '0;
      else if (restart || tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, oversampled start/data/stop
// FSM, valid/ready byte output, frame-error and overrun pulses.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk100M,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int unsigned TW  = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

   logic [1:0]    sync_q;
   logic          rx_s;
   rx_state_e     state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          restart;
   logic          tick;
   logic          stop_good;
   logic          stop_bad;
   logic          load;

   assign rx_s = sync_q[1];

   uart_rx_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk100M (clk100M),
      .rst_n   (rst_n),
      .restart (restart),
      .tick    (tick)
   );

   // Two-flop synchronizer for the asynchronous line; resets to idle-high.
   always_ff @(posedge clk100M or negedge rst_n) begin
      if (!rst_n)
         sync_q <= 2'b11;
      else
         sync_q <= {sync_q[0], uart_rx};
   end

   // FSM and frame counters: state register.
   always_ff @(posedge clk100M or negedge rst_n) begin
      // NOTE: shift is reset too, so a mid-frame reset leaves no stale partial byte.
      if (!rst_n) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
      end
   end

   // FSM next-state: start qualification, data sampling, stop check.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      restart    = 1'b0;
      stop_good  = 1'b0;
      stop_bad   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d    = START;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               restart    = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt_q == MID_TICK) begin
                  tick_cnt_d = '0;
                  // A line that is high again at mid start bit was a glitch.
                  state_d    = rx_s ? IDLE : DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tick_cnt_q == LAST_TICK) begin
                  tick_cnt_d         = '0;
                  shift_d[bit_cnt_q] = rx_s;
                  bit_cnt_d          = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7)
                     state_d = STOP;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (tick_cnt_q == LAST_TICK) begin
                  tick_cnt_d = '0;
                  // Leaving mid stop bit lets a back-to-back start edge be caught.
                  if (rx_s) begin
                     stop_good = 1'b1;
                     state_d   = IDLE;
                  end else begin
                     stop_bad  = 1'b1;
                     state_d   = WAIT_HIGH;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_s)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A completed byte is taken only if the output slot is free or being drained.
   assign load = stop_good && (!rx_valid || rx_ready);

   // Output register: byte/valid handshake and one-cycle error pulses.
   always_ff @(posedge clk100M or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= stop_good && !load;
         if (load) begin
            rx_data  <= shift_q;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
